lab2_adder_arbiter: RTL and testbench

- Shares one registered W-bit adder between two requesters, each with its own valid/ready request channel and valid/ready response channel.
- Round-robin arbitration; a single operation is in flight at a time.
- Each operand pair carries a 1-bit tag that is passed through unchanged, in the same way the lab adder passes its top bit through.
- Sits between the tile I/O decode and the lab adder datapath. It sequences and shares the adder rather than instantiating one per requester.

---
 rtl/lab2_adder_arbiter.sv | 145 ++++++++++++++
 tb/tb_lab2_adder_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_adder_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder between two valid/ready requesters.
// Optional build macro: LAB2_ADDER_SAT_EN (saturate sum to all-ones on carry-out).

// state | meaning
// IDLE  | waiting for a request; grants and captures operands on the edge
// EXEC  | adder result registered into rsp_sum/rsp_carry/rsp_tag
// RESP  | result presented to the grantee until it takes it
module lab2_adder_arbiter #(
  parameter int W     = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_b0,
  input  logic             req_tag0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b1,
  input  logic             req_tag1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [W-1:0]     rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             grant_q, grant_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             tag_q, tag_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             rtag_q, rtag_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic             pick;
  logic             accept;
  logic [W:0]       add_full;
  logic [W-1:0]     sum_res;

  // A lone requester wins regardless of rr_ptr; rsp_ready never reaches this path.
  always_comb begin
    pick = rr_ptr_q;
    if (req_valid == 2'b01)      pick = 1'b0;
    else if (req_valid == 2'b10) pick = 1'b1;
    accept    = (state_q == IDLE) && (req_valid != 2'b00) && !rst;
    req_ready = accept ? (pick ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    add_full = {1'b0, a_q} + {1'b0, b_q};
`ifdef LAB2_ADDER_SAT_EN
    sum_res = add_full[W] ? {W{1'b1}} : add_full[W-1:0];
`else
    sum_res = add_full[W-1:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    rtag_d   = rtag_q;
    ops_d    = ops_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = pick;
          a_d     = pick ? req_a1   : req_a0;
          b_d     = pick ? req_b1   : req_b0;
          tag_d   = pick ? req_tag1 : req_tag0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = sum_res;
        carry_d = add_full[W];
        rtag_d  = tag_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          ops_d    = ops_q + CNT_W'(1);
          rr_ptr_d = ~grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      grant_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      rtag_q      <= 1'b0;
      ops_q       <= '0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      rtag_q      <= rtag_d;
      ops_q       <= ops_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_tag   = rtag_q;
  assign busy      = busy_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_lab2_adder_arbiter.sv
// Scoreboard bench for lab2_adder_arbiter (W=7); a second CNT_W=2 instance shares the stimulus.
module tb_lab2_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, rsp_ready;
  logic [6:0] req_a0, req_b0, req_a1, req_b1;
  logic       req_tag0, req_tag1;

  logic [1:0] req_ready, rsp_valid;
  logic [6:0] rsp_sum;
  logic       rsp_carry, rsp_tag, busy;
  logic [7:0] ops_done;

  logic [1:0] w_req_ready, w_rsp_valid;
  logic [6:0] w_rsp_sum;
  logic       w_rsp_carry, w_rsp_tag, w_busy;
  logic [1:0] w_ops_done;

  typedef struct {
    logic [1:0] vld;
    logic [6:0] sum;
    logic       carry;
    logic       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_ops = 0;

  always #5 clk = ~clk;

  lab2_adder_arbiter #(.W(7), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_tag0(req_tag0),
    .req_a1(req_a1), .req_b1(req_b1), .req_tag1(req_tag1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .busy(busy), .ops_done(ops_done)
  );

  lab2_adder_arbiter #(.W(7), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_tag0(req_tag0),
    .req_a1(req_a1), .req_b1(req_b1), .req_tag1(req_tag1),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(w_rsp_sum),
    .rsp_carry(w_rsp_carry), .rsp_tag(w_rsp_tag), .busy(w_busy), .ops_done(w_ops_done)
  );

  function automatic exp_t mk(input int r, input int a, input int b, input logic tag);
    exp_t e;
    int   s;
    s       = a + b;
    e.vld   = (r == 0) ? 2'b01 : 2'b10;
    e.carry = (s > 127);
    e.sum   = 7'(s % 128);
`ifdef LAB2_ADDER_SAT_EN
    if (e.carry) e.sum = 7'h7f;
`endif
    e.tag   = tag;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_tag0 = 1'b0;
    req_a1 = '0; req_b1 = '0; req_tag1 = 1'b0;
    tick(); tick();
    req_valid = 2'b11;
    #1;
    n_vec++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL reset_req_ready got %b exp 00", req_ready);
    end
    n_vec++;
    if ({rsp_valid, rsp_sum, rsp_carry, rsp_tag, busy, ops_done} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_outputs got vld=%b sum=%0d c=%b t=%b busy=%b ops=%0d exp all 0",
               rsp_valid, rsp_sum, rsp_carry, rsp_tag, busy, ops_done);
    end
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    req_valid = 2'b11;
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL reset_rr_ptr got %b exp 01", req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_single_op();
    exp_t e;
    req_valid = 2'b01; req_a0 = 7'd10; req_b0 = 7'd20; req_tag0 = 1'b1; rsp_ready = 2'b01;
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_req_ready got %b exp 01", req_ready);
    end
    sb.push_back(mk(0, 10, 20, 1'b1));
    tick();
    req_valid = 2'b00;
    n_vec++;
    if ({busy, rsp_valid, req_ready} !== 5'b10000) begin
      n_err++; $display("FAIL single_exec got busy=%b vld=%b rdy=%b exp 1/00/00", busy, rsp_valid, req_ready);
    end
    tick();
    e = sb.pop_front();
    n_vec++;
    if ({rsp_valid, rsp_sum, rsp_carry, rsp_tag} !== {e.vld, e.sum, e.carry, e.tag}) begin
      n_err++; $display("FAIL single_rsp got vld=%b sum=%0d c=%b t=%b exp vld=%b sum=%0d c=%b t=%b",
                        rsp_valid, rsp_sum, rsp_carry, rsp_tag, e.vld, e.sum, e.carry, e.tag);
    end
    tick();
    exp_ops++;
    n_vec++;
    if ({busy, rsp_valid, ops_done} !== {1'b0, 2'b00, 8'(exp_ops)}) begin
      n_err++; $display("FAIL single_done got busy=%b vld=%b ops=%0d exp 0/00/%0d", busy, rsp_valid, ops_done, exp_ops);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    req_valid = 2'b10; req_a1 = 7'd100; req_b1 = 7'd50; req_tag1 = 1'b0; rsp_ready = 2'b10;
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL ovf_req_ready got %b exp 10", req_ready);
    end
    sb.push_back(mk(1, 100, 50, 1'b0));
    tick();
    req_valid = 2'b00;
    tick();
    e = sb.pop_front();
    n_vec++;
    if ({rsp_valid, rsp_sum, rsp_carry, rsp_tag} !== {e.vld, e.sum, e.carry, e.tag}) begin
      n_err++; $display("FAIL ovf_rsp got vld=%b sum=%0d c=%b t=%b exp vld=%b sum=%0d c=%b t=%b",
                        rsp_valid, rsp_sum, rsp_carry, rsp_tag, e.vld, e.sum, e.carry, e.tag);
    end
    tick();
    exp_ops++;
  endtask

  task automatic test_contention();
    exp_t e;
    int   g, a0, b0, a1, b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      g  = i % 2;
      a0 = 10 + i * 9; b0 = 3 * i + 1; a1 = 90 + i * 7; b1 = 20 + i * 5;
      req_a0 = 7'(a0); req_b0 = 7'(b0); req_tag0 = (i % 2 == 1);
      req_a1 = 7'(a1); req_b1 = 7'(b1); req_tag1 = (i % 2 == 0);
      req_valid = 2'b11;
      #1;
      n_vec++;
      if (req_ready !== ((g == 1) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL cont_grant op%0d got %b exp grant %0d", i, req_ready, g);
      end
      sb.push_back(g == 1 ? mk(1, a1, b1, req_tag1) : mk(0, a0, b0, req_tag0));
      tick();
      req_a0 = 7'($urandom); req_b0 = 7'($urandom); req_tag0 = ~req_tag0;
      req_a1 = 7'($urandom); req_b1 = 7'($urandom); req_tag1 = ~req_tag1;
      n_vec++;
      if ({busy, req_ready} !== 3'b100) begin
        n_err++; $display("FAIL cont_exec op%0d got busy=%b rdy=%b exp 1/00", i, busy, req_ready);
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({rsp_valid, rsp_sum, rsp_carry, rsp_tag} !== {e.vld, e.sum, e.carry, e.tag}) begin
        n_err++; $display("FAIL cont_rsp op%0d got vld=%b sum=%0d c=%b t=%b exp vld=%b sum=%0d c=%b t=%b",
                          i, rsp_valid, rsp_sum, rsp_carry, rsp_tag, e.vld, e.sum, e.carry, e.tag);
      end
      tick();
      exp_ops++;
    end
    req_valid = 2'b00;
    n_vec++;
    if (ops_done !== 8'(exp_ops)) begin
      n_err++; $display("FAIL cont_ops got %0d exp %0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    req_valid = 2'b01; req_a0 = 7'd60; req_b0 = 7'd70; req_tag0 = 1'b1; rsp_ready = 2'b00;
    #1;
    sb.push_back(mk(0, 60, 70, 1'b1));
    tick();
    req_valid = 2'b00;
    tick();
    e = sb.pop_front();
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      rsp_ready = (i < 5) ? 2'b00 : 2'b10;
      #1;
      n_vec++;
      if ({rsp_valid, rsp_sum, rsp_carry, rsp_tag, req_ready, busy} !== {e.vld, e.sum, e.carry, e.tag, 2'b00, 1'b1}) begin
        n_err++; $display("FAIL bp_hold cyc%0d got vld=%b sum=%0d c=%b t=%b rdy=%b busy=%b exp vld=%b sum=%0d c=%b t=%b rdy=00 busy=1",
                          i, rsp_valid, rsp_sum, rsp_carry, rsp_tag, req_ready, busy, e.vld, e.sum, e.carry, e.tag);
      end
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    exp_ops++;
    n_vec++;
    if ({busy, rsp_valid, req_ready, ops_done} !== {1'b0, 2'b00, 2'b10, 8'(exp_ops)}) begin
      n_err++; $display("FAIL bp_release got busy=%b vld=%b rdy=%b ops=%0d exp 0/00/10/%0d",
                        busy, rsp_valid, req_ready, ops_done, exp_ops);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    req_valid = 2'b01; req_a0 = 7'd33; req_b0 = 7'd44; req_tag0 = 1'b1; rsp_ready = 2'b11;
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL lone_grant got %b exp 01", req_ready);
    end
    sb.push_back(mk(0, 33, 44, 1'b1));
    tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_tag, busy, ops_done, w_ops_done} !== 24'd0) begin
      n_err++; $display("FAIL midrst_zero got rdy=%b vld=%b sum=%0d c=%b t=%b busy=%b ops=%0d wops=%0d exp all 0",
                        req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_tag, busy, ops_done, w_ops_done);
    end
    sb.delete();
    exp_ops = 0;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({rsp_valid, busy} !== 3'b000) begin
        n_err++; $display("FAIL midrst_stale cyc%0d got vld=%b busy=%b exp 00/0", i, rsp_valid, busy);
      end
    end
    req_valid = 2'b10; req_a1 = 7'd5; req_b1 = 7'd6; req_tag1 = 1'b1; rsp_ready = 2'b10;
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL midrst_req1 got %b exp 10", req_ready);
    end
    sb.push_back(mk(1, 5, 6, 1'b1));
    tick();
    req_valid = 2'b00;
    tick();
    e = sb.pop_front();
    n_vec++;
    if ({rsp_valid, rsp_sum, rsp_carry, rsp_tag} !== {e.vld, e.sum, e.carry, e.tag}) begin
      n_err++; $display("FAIL midrst_rsp got vld=%b sum=%0d c=%b t=%b exp vld=%b sum=%0d c=%b t=%b",
                        rsp_valid, rsp_sum, rsp_carry, rsp_tag, e.vld, e.sum, e.carry, e.tag);
    end
    tick();
    exp_ops++;
    req_valid = 2'b11;
    #1;
    n_vec++;
    if ({req_ready, ops_done} !== {2'b01, 8'(exp_ops)}) begin
      n_err++; $display("FAIL midrst_after got rdy=%b ops=%0d exp 01/%0d", req_ready, ops_done, exp_ops);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_counter_wrap();
    exp_t e;
    int   wrap_seq[5] = '{1, 2, 3, 0, 1};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops = 0;
    tick();
    rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'b01; req_a0 = 7'(i * 20); req_b0 = 7'(i * 11 + 1); req_tag0 = (i % 2 == 0);
      #1;
      sb.push_back(mk(0, i * 20, i * 11 + 1, req_tag0));
      tick();
      req_valid = 2'b00;
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({rsp_valid, rsp_sum, rsp_carry, rsp_tag} !== {e.vld, e.sum, e.carry, e.tag}) begin
        n_err++; $display("FAIL wrap_rsp op%0d got vld=%b sum=%0d c=%b t=%b exp vld=%b sum=%0d c=%b t=%b",
                          i, rsp_valid, rsp_sum, rsp_carry, rsp_tag, e.vld, e.sum, e.carry, e.tag);
      end
      tick();
      exp_ops++;
      n_vec++;
      if ({w_ops_done, ops_done} !== {2'(wrap_seq[i]), 8'(exp_ops)}) begin
        n_err++; $display("FAIL wrap_ops op%0d got w=%0d main=%0d exp w=%0d main=%0d",
                          i, w_ops_done, ops_done, wrap_seq[i], exp_ops);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_counter_wrap();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
